pkt_fifo_ctrl: RTL
==================

# pkt_fifo_ctrl

Store-and-forward byte FIFO with per-byte SOF/EOF sidebands, sitting directly upstream of the UDP parser. It accepts an Ethernet frame stream from the receive side and exposes only complete, error-free frames on a first-word-fall-through read port. The read port connects directly to the parser's `in_rd_en` / `in_empty` / `in_dout` / `in_sof` / `in_eof`. Frames that are flagged bad, overflow the buffer, or are truncated are rolled back and never become visible to the reader.

## Interface
- `ADDR_W`, default 10: log2 of storage depth in bytes (DEPTH = 2^ADDR_W).
- `clock` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_wr_en` in 1: write strobe for the current byte.
- `in_din` in 8: frame byte.
- `in_sof` in 1: byte is the first byte of a frame.
- `in_eof` in 1: byte is the last byte of a frame.
- `in_err` in 1: sampled only with `in_eof`; 1 discards the whole frame.
- `in_full` out 1: no free entry for a write.
- `out_rd_en` in 1: pop the head entry.
- `out_empty` out 1: no committed byte is available.
- `out_dout` out 8: head byte.
- `out_sof` out 1: SOF flag of the head byte.
- `out_eof` out 1: EOF flag of the head byte.
- `drop_cnt` out 16: frames discarded, saturating at 16'hFFFF.
- `frame_cnt` out 16: frames committed, wrapping.

## Operation
- **Storage:** DEPTH x 10-bit array holding {sof, eof, byte}.
- **Pointers:** three (ADDR_W+1)-bit pointers: `wr_ptr` (speculative), `commit_ptr`, `rd_ptr`. The extra MSB distinguishes full from empty.
- **Status flags:**
  - `out_empty` = (`rd_ptr` == `commit_ptr`).
  - `in_full` = (`wr_ptr` − `rd_ptr` == DEPTH).
- **Write FSM states:** W_IDLE, W_FRAME, W_DROP.
  - W_IDLE: a write with `in_sof`=0 is ignored.
    - `in_sof`=1 stores the byte and goes to W_FRAME.
    - If `in_eof` is also 1 (one-byte frame), the byte is committed or dropped immediately per the EOF rule and the FSM stays in W_IDLE.
  - W_FRAME: each write stores the byte and increments `wr_ptr`.
  - W_FRAME, write with `in_eof`=1:
    - `in_err`=0: store, `commit_ptr` ← `wr_ptr`+1, `frame_cnt`++, go to W_IDLE.
    - `in_err`=1: `wr_ptr` ← `commit_ptr`, `drop_cnt`++, go to W_IDLE.
  - W_FRAME, write with `in_sof`=1 (missing EOF): roll back the unfinished frame and count a drop. In the same edge, store the new byte at the rolled-back `wr_ptr` and stay in W_FRAME.
  - W_FRAME, write while `in_full`=1 (overflow): `wr_ptr` ← `commit_ptr`, go to W_DROP. The drop is counted at EOF. A frame longer than DEPTH therefore always drops.
  - W_DROP: all writes are ignored until one with `in_eof`=1; on that write, `drop_cnt`++ and go to W_IDLE.
  - W_DROP, write with `in_sof`=1: count the drop, then treat the byte exactly as in W_IDLE.
- **Read side:**
  - `out_dout` / `out_sof` / `out_eof` are the array entry at `rd_ptr`, read asynchronously.
  - All three are forced to 0 while `out_empty`=1.
  - `out_rd_en` & !`out_empty` advances `rd_ptr`. `out_rd_en` while empty is ignored.
- Simultaneous read and write are independent.
- `in_full` uses `rd_ptr`, so space freed by a pop is writable from the next cycle.

## Timing
- **Reset (async assert, sync release):** all pointers 0, FSM W_IDLE, `out_empty`=1, `in_full`=0, `out_dout`/`out_sof`/`out_eof`=0, `drop_cnt`=0, `frame_cnt`=0.
- Reset mid-frame discards all contents, both committed and uncommitted.
- **Latency:** the EOF write at edge N commits the frame. `out_empty` falls and `out_sof`/`out_dout` show the frame's first byte after edge N (visible in cycle N+1).
- **FWFT behaviour:** the head is valid in the same cycle `out_empty`=0. After a pop at edge M, the next byte is on `out_dout` in cycle M+1. There is no stale byte and no extra read-latency cycle, so the reader may pop every cycle.
- `in_full` is combinational from the pointers. The writer must not write while it is high; such a write triggers overflow handling.
- A rollback and a pop in the same edge are both applied.

## Test plan
- **Single frame:** 42-byte frame, `in_err`=0, no reads until EOF. Required: `out_empty` stays 1 until the cycle after the EOF write. Read back all 42 bytes in order, `out_sof` on byte 0, `out_eof` on byte 41, then `out_empty`=1 and `frame_cnt`=1.
- **Error drop:** 60-byte frame with `in_err`=1 at EOF, followed by a good 50-byte frame. Required: only the 50-byte frame is read, `drop_cnt`=1, `frame_cnt`=1.
- **Overflow:** `ADDR_W`=6, 70-byte frame with no reads, then a good 20-byte frame. Required: the 70-byte frame is fully discarded, `drop_cnt`=1, and the 20-byte frame is read intact.
- **Missing EOF:** 10 bytes of a frame, then `in_sof`=1 starting a 12-byte good frame. Required: only the 12 bytes are read, `drop_cnt`=1. Bytes written with no SOF while idle are never output.
- **Full-throughput streaming:** back-to-back 64-byte frames with `out_rd_en` held high and concurrent writes. Required: no byte loss or duplication, `in_full` never asserts, and `out_dout` advances every cycle while not empty.
- **Reset mid-frame:** deassert `reset_n` after 30 bytes with 1 committed frame unread. Required: `out_empty`=1, both counters 0, and the next frame is read cleanly.

Source files
------------

// File: rtl/pkt_fifo_ctrl.sv
// Store-and-forward byte FIFO: frames become readable only once committed at a good EOF.
// Bad, truncated or overflowing frames are rolled back to the commit pointer.
module pkt_fifo_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_wr_en,
   input  logic [7:0]  in_din,
   input  logic        in_sof,
   input  logic        in_eof,
   input  logic        in_err,
   output logic        in_full,
   input  logic        out_rd_en,
   output logic        out_empty,
   output logic [7:0]  out_dout,
   output logic        out_sof,
   output logic        out_eof,
   output logic [15:0] drop_cnt,
   output logic [15:0] frame_cnt
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef logic [ADDR_W:0] ptr_t;
   typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} wstate_e;

   localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

   logic [9:0]        mem [DEPTH];
   ptr_t              wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
   wstate_e           state_q, state_d;
   logic [15:0]       drop_q, drop_d, frame_q, frame_d;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        drop_inc;
   logic [16:0]       drop_sum;
   logic              start;
   ptr_t              base;
   logic              base_full;
   logic [9:0]        head;

   assign out_empty = (rd_q == commit_q);
   assign in_full   = ((wr_q - rd_q) == DEPTH_P);
   assign head      = mem[rd_q[ADDR_W-1:0]];
   assign out_dout  = out_empty ? '0 : head[7:0];
   assign out_eof   = out_empty ? 1'b0 : head[8];
   assign out_sof   = out_empty ? 1'b0 : head[9];
   assign drop_cnt  = drop_q;
   assign frame_cnt = frame_q;

   always_comb begin
      wr_d      = wr_q;
      commit_d  = commit_q;
      state_d   = state_q;
      frame_d   = frame_q;
      drop_inc  = '0;
      mem_we    = 1'b0;
      mem_addr  = wr_q[ADDR_W-1:0];
      start     = 1'b0;
      base      = wr_q;
      base_full = in_full;
      rd_d      = rd_q + ptr_t'(out_rd_en && !out_empty);

      if (in_wr_en) begin
         case (state_q)
            W_IDLE: start = in_sof;
            W_FRAME: begin
               if (in_sof) begin
                  // missing EOF: abandon the open frame, restart at the commit point
                  drop_inc  = 2'd1;
                  start     = 1'b1;
                  base      = commit_q;
                  base_full = ((commit_q - rd_q) == DEPTH_P);
               end else if (in_full) begin
                  wr_d = commit_q;
                  if (in_eof) begin
                     drop_inc = 2'd1;
                     state_d  = W_IDLE;
                  end else begin
                     state_d = W_DROP;
                  end
               end else begin
                  mem_we = 1'b1;
                  if (in_eof) begin
                     state_d = W_IDLE;
                     if (in_err) begin
                        wr_d     = commit_q;
                        drop_inc = 2'd1;
                     end else begin
                        wr_d     = wr_q + 1'b1;
                        commit_d = wr_q + 1'b1;
                        frame_d  = frame_q + 16'd1;
                     end
                  end else begin
                     wr_d = wr_q + 1'b1;
                  end
               end
            end
            W_DROP: begin
               if (in_sof) begin
                  drop_inc = 2'd1;
                  start    = 1'b1;
               end else if (in_eof) begin
                  drop_inc = 2'd1;
                  state_d  = W_IDLE;
               end
            end
            default: state_d = W_IDLE;
         endcase
      end

      // first byte of a frame, written at base (wr_ptr, or commit_ptr after a rollback)
      if (start) begin
         if (base_full) begin
            wr_d = base;
            if (in_eof) begin
               drop_inc = drop_inc + 2'd1;
               state_d  = W_IDLE;
            end else begin
               state_d = W_DROP;
            end
         end else begin
            mem_we   = 1'b1;
            mem_addr = base[ADDR_W-1:0];
            if (in_eof) begin
               state_d = W_IDLE;
               if (in_err) begin
                  wr_d     = base;
                  drop_inc = drop_inc + 2'd1;
               end else begin
                  wr_d     = base + 1'b1;
                  commit_d = base + 1'b1;
                  frame_d  = frame_q + 16'd1;
               end
            end else begin
               wr_d    = base + 1'b1;
               state_d = W_FRAME;
            end
         end
      end

      drop_sum = {1'b0, drop_q} + 17'(drop_inc);
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_q     <= '0;
         commit_q <= '0;
         rd_q     <= '0;
         state_q  <= W_IDLE;
         drop_q   <= '0;
         frame_q  <= '0;
      end else begin
         wr_q     <= wr_d;
         commit_q <= commit_d;
         rd_q     <= rd_d;
         state_q  <= state_d;
         drop_q   <= drop_d;
         frame_q  <= frame_d;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_addr] <= {in_sof, in_eof, in_din};
   end

endmodule
